// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types and defaults for the committed-load stride detector.
// Entry struct and descriptor width are macros so each user picks its own widths.
`define DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_mp, stride_width_mp, conf_width_mp, loop_range_mp) \
    typedef struct packed {                                    \
        logic                        v;                         \
        logic [vaddr_width_mp-1:0]   tag;                       \
        logic [vaddr_width_mp-1:0]   last_addr;                 \
        logic [stride_width_mp-1:0]  stride;                    \
        logic [conf_width_mp-1:0]    conf;                      \
        logic [loop_range_mp-1:0]    cooldown;                  \
    } bp_be_stride_entry_s

`define BP_BE_STRIDE_DESC_WIDTH(vaddr_width_mp, stride_width_mp, loop_range_mp) \
    (2*(vaddr_width_mp) + (stride_width_mp) + (loop_range_mp))

package bp_be_stride_detector_pkg;
    localparam int unsigned default_vaddr_width_gp  = 39;
    localparam int unsigned default_entries_gp      = 8;
    localparam int unsigned default_loop_range_gp   = 8;
    localparam int unsigned default_stride_width_gp = 8;
    localparam int unsigned default_conf_width_gp   = 2;
    localparam int unsigned default_conf_thresh_gp  = 2;
    localparam int unsigned default_depth_gp        = 4;
endpackage

// File: rtl/bp_be_stride_detector_table.sv
// Fully-associative reference prediction table: CAM lookup, round-robin
// allocation and per-entry stride/confidence/cooldown update.
module bp_be_stride_detector_table
    import bp_be_stride_detector_pkg::*;
#(
    parameter int unsigned vaddr_width_p  = default_vaddr_width_gp,
    parameter int unsigned entries_p      = default_entries_gp,
    parameter int unsigned loop_range_p   = default_loop_range_gp,
    parameter int unsigned stride_width_p = default_stride_width_gp,
    parameter int unsigned conf_width_p   = default_conf_width_gp,
    parameter int unsigned depth_p        = default_depth_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [vaddr_width_p-1:0]  commit_eff_addr_i,
    input  logic                      flush_i,
    input  logic                      trigger_i,
    output logic                      hit_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [conf_width_p-1:0]   conf_o,
    output logic [loop_range_p-1:0]   cooldown_o
);
    localparam int unsigned idx_w_lp = $clog2(entries_p);

    `DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_p, stride_width_p, conf_width_p, loop_range_p);

    bp_be_stride_entry_s tbl_q [entries_p];
    bp_be_stride_entry_s tbl_d [entries_p];
    logic [idx_w_lp-1:0] ptr_q, ptr_d;

    logic                      hit;
    logic [idx_w_lp-1:0]       hit_idx;
    bp_be_stride_entry_s       hit_e, upd_e;
    logic [vaddr_width_p-1:0]  delta;
    logic                      fits, match;
    logic [stride_width_p-1:0] new_stride;
    logic [conf_width_p-1:0]   new_conf;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < entries_p; i++) begin
            if (tbl_q[i].v && tbl_q[i].tag == commit_pc_i) begin
                hit     = 1'b1;
                hit_idx = idx_w_lp'(i);
            end
        end
    end

    // Unsigned delta: backwards or oversized steps never fit and reset training
    always_comb begin
        hit_e = tbl_q[hit_idx];
        delta = commit_eff_addr_i - hit_e.last_addr;
        fits  = (delta != '0) && (delta[vaddr_width_p-1:stride_width_p] == '0);
        match = fits && (delta[stride_width_p-1:0] == hit_e.stride);
        if (match) begin
            new_stride = hit_e.stride;
            new_conf   = (&hit_e.conf) ? hit_e.conf : hit_e.conf + conf_width_p'(1);
        end else begin
            new_stride = fits ? delta[stride_width_p-1:0] : '0;
            new_conf   = '0;
        end
    end

    assign hit_o      = commit_v_i & hit & ~flush_i;
    assign stride_o   = new_stride;
    assign conf_o     = new_conf;
    assign cooldown_o = hit_e.cooldown;

    always_comb begin
        tbl_d = tbl_q;
        ptr_d = ptr_q;
        upd_e = hit_e;
        upd_e.last_addr = commit_eff_addr_i;
        upd_e.stride    = new_stride;
        upd_e.conf      = new_conf;
        if (!match)
            upd_e.cooldown = '0;
        else if (trigger_i)
            upd_e.cooldown = loop_range_p'(depth_p);
        else if (hit_e.cooldown != '0)
            upd_e.cooldown = hit_e.cooldown - loop_range_p'(1);
        if (flush_i) begin
            for (int i = 0; i < entries_p; i++)
                tbl_d[i].v = 1'b0;
            ptr_d = '0;
        end else if (commit_v_i) begin
            if (hit) begin
                tbl_d[hit_idx] = upd_e;
            end else begin
                tbl_d[ptr_q] = '{v: 1'b1, tag: commit_pc_i,
                                 last_addr: commit_eff_addr_i,
                                 stride: '0, conf: '0, cooldown: '0};
                ptr_d = (ptr_q == idx_w_lp'(entries_p - 1))
                      ? '0 : ptr_q + idx_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < entries_p; i++)
                tbl_q[i] <= '0;
            ptr_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/bp_be_stride_detector.sv
// Stride detector top: trigger decision and single-entry descriptor buffer
// feeding the prefetch generator's striding-load port.
module bp_be_stride_detector
    import bp_be_stride_detector_pkg::*;
#(
    parameter int unsigned vaddr_width_p  = default_vaddr_width_gp,
    parameter int unsigned entries_p      = default_entries_gp,
    parameter int unsigned loop_range_p   = default_loop_range_gp,
    parameter int unsigned stride_width_p = default_stride_width_gp,
    parameter int unsigned conf_width_p   = default_conf_width_gp,
    parameter int unsigned conf_thresh_p  = default_conf_thresh_gp,
    parameter int unsigned depth_p        = default_depth_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [vaddr_width_p-1:0]  commit_eff_addr_i,
    input  logic                      flush_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [vaddr_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o
);
    localparam int unsigned desc_w_lp =
        `BP_BE_STRIDE_DESC_WIDTH(vaddr_width_p, stride_width_p, loop_range_p);

    logic                      hit;
    logic [stride_width_p-1:0] upd_stride;
    logic [conf_width_p-1:0]   upd_conf;
    logic [loop_range_p-1:0]   cooldown;
    logic                      trigger;

    logic                 v_q, v_d;
    logic [desc_w_lp-1:0] desc_q, desc_d;

    bp_be_stride_detector_table #(
        .vaddr_width_p  (vaddr_width_p),
        .entries_p      (entries_p),
        .loop_range_p   (loop_range_p),
        .stride_width_p (stride_width_p),
        .conf_width_p   (conf_width_p),
        .depth_p        (depth_p)
    ) table_u (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_eff_addr_i (commit_eff_addr_i),
        .flush_i           (flush_i),
        .trigger_i         (trigger),
        .hit_o             (hit),
        .stride_o          (upd_stride),
        .conf_o            (upd_conf),
        .cooldown_o        (cooldown)
    );

    // A full, non-draining buffer drops the trigger; cooldown stays 0 so it retries
    assign trigger = hit
                   & (upd_conf >= conf_width_p'(conf_thresh_p))
                   & (upd_stride != '0)
                   & (cooldown == '0)
                   & (~v_q | ready_and_i);

    always_comb begin
        v_d    = v_q;
        desc_d = desc_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (trigger) begin
            v_d    = 1'b1;
            desc_d = {commit_pc_i, commit_eff_addr_i, upd_stride,
                      loop_range_p'(depth_p)};
        end else if (v_q & ready_and_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            desc_q <= '0;
        end else begin
            v_q    <= v_d;
            desc_q <= desc_d;
        end
    end

    assign v_o = v_q;
    assign {pc_o, eff_addr_o, stride_o, loop_counter_o} = desc_q;
endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed and randomized bench for bp_be_stride_detector against a
// behavioural per-PC stream model.
module tb_bp_be_stride_detector;
    localparam int VA = 39;
    localparam int N  = 8;
    localparam int LR = 8;
    localparam int SW = 8;
    localparam int CW = 2;
    localparam int TH = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          commit_v;
    logic [VA-1:0] commit_pc;
    logic [VA-1:0] commit_ea;
    logic          flush;
    logic          v_o;
    logic          ready;
    logic [VA-1:0] pc_o;
    logic [VA-1:0] ea_o;
    logic [SW-1:0] stride_o;
    logic [LR-1:0] loop_o;

    always #5 clk = ~clk;

    bp_be_stride_detector #(
        .vaddr_width_p (VA), .entries_p (N), .loop_range_p (LR),
        .stride_width_p (SW), .conf_width_p (CW),
        .conf_thresh_p (TH), .depth_p (DP)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (rst_n),
        .commit_v_i        (commit_v),
        .commit_pc_i       (commit_pc),
        .commit_eff_addr_i (commit_ea),
        .flush_i           (flush),
        .v_o               (v_o),
        .ready_and_i       (ready),
        .pc_o              (pc_o),
        .eff_addr_o        (ea_o),
        .stride_o          (stride_o),
        .loop_counter_o    (loop_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one record per tracked PC, plus a one-slot queue
    bit            m_v    [N];
    logic [VA-1:0] m_tag  [N];
    logic [VA-1:0] m_last [N];
    int            m_str  [N];
    int            m_conf [N];
    int            m_cd   [N];
    int            m_ptr;
    bit            m_bv;
    logic [VA-1:0] m_pc, m_ea;
    int            m_st;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_last[i] = '0;
            m_str[i] = 0; m_conf[i] = 0; m_cd[i] = 0;
        end
        m_ptr = 0; m_bv = 0; m_pc = '0; m_ea = '0; m_st = 0;
    endfunction

    function automatic void m_update(bit cv, logic [VA-1:0] pc,
                                     logic [VA-1:0] ea, bit fl, bit rdy);
        int h;
        logic [VA-1:0] d;
        bit fits, same, trig;
        if (fl) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            m_ptr = 0;
            m_bv  = 0;
            return;
        end
        trig = 0;
        h = -1;
        if (cv) begin
            for (int i = 0; i < N; i++)
                if (m_v[i] && m_tag[i] == pc) h = i;
            if (h < 0) begin
                m_v[m_ptr] = 1; m_tag[m_ptr] = pc; m_last[m_ptr] = ea;
                m_str[m_ptr] = 0; m_conf[m_ptr] = 0; m_cd[m_ptr] = 0;
                m_ptr = (m_ptr + 1) % N;
            end else begin
                d    = ea - m_last[h];
                fits = (d > 0) && (d < (1 << SW));
                same = fits && (d == VA'(m_str[h]));
                if (same) begin
                    if (m_conf[h] < (1 << CW) - 1) m_conf[h]++;
                end else begin
                    m_conf[h] = 0;
                    m_str[h]  = fits ? int'(d) : 0;
                end
                m_last[h] = ea;
                trig = (m_conf[h] >= TH) && (m_str[h] != 0) &&
                       (m_cd[h] == 0) && (!m_bv || rdy);
                if (!same)          m_cd[h] = 0;
                else if (trig)      m_cd[h] = DP;
                else if (m_cd[h] > 0) m_cd[h]--;
                if (trig) begin
                    m_pc = pc; m_ea = ea; m_st = m_str[h];
                end
            end
        end
        if (trig)             m_bv = 1;
        else if (m_bv && rdy) m_bv = 0;
    endfunction

    task automatic compare(string tag);
        chk({tag, ".v"}, 64'(v_o), 64'(m_bv));
        if (m_bv) begin
            chk({tag, ".pc"},     64'(pc_o),     64'(m_pc));
            chk({tag, ".ea"},     64'(ea_o),     64'(m_ea));
            chk({tag, ".stride"}, 64'(stride_o), 64'(m_st));
            chk({tag, ".loop"},   64'(loop_o),   64'(DP));
        end
    endtask

    task automatic step(string tag, bit cv, logic [VA-1:0] pc,
                        logic [VA-1:0] ea, bit fl, bit rdy);
        commit_v  = cv;
        commit_pc = pc;
        commit_ea = ea;
        flush     = fl;
        ready     = rdy;
        @(posedge clk);
        m_update(cv, pc, ea, fl, rdy);
        #1;
        compare(tag);
    endtask

    task automatic idle(string tag, bit rdy);
        step(tag, 1'b0, '0, '0, 1'b0, rdy);
    endtask

    logic [VA-1:0] r_pc  [10];
    logic [VA-1:0] r_cur [10];
    int            r_str [10];

    initial begin
        rst_n = 1'b0;
        commit_v = 0; commit_pc = '0; commit_ea = '0; flush = 0; ready = 1;
        m_reset();
        #12;
        chk("rst.v", 64'(v_o), 64'd0);
        chk("rst.pc", 64'(pc_o), 64'd0);
        chk("rst.ea", 64'(ea_o), 64'd0);
        chk("rst.stride", 64'(stride_o), 64'd0);
        chk("rst.loop", 64'(loop_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic stream: one descriptor after the fourth access
        for (int k = 0; k < 4; k++)
            step("stream", 1, 'h1000, VA'('h2000 + 8 * k), 0, 1);
        chk("stream.trig_v", 64'(v_o), 64'd1);
        chk("stream.trig_ea", 64'(ea_o), 64'h2018);
        chk("stream.trig_stride", 64'(stride_o), 64'd8);
        chk("stream.trig_loop", 64'(loop_o), 64'd4);

        // cooldown: four quiet hits, then re-trigger at 0x2040
        for (int k = 4; k < 9; k++)
            step("cool", 1, 'h1000, VA'('h2000 + 8 * k), 0, 1);
        chk("cool.trig_ea", 64'(ea_o), 64'h2040);

        // backpressure: held descriptor, dropped trigger, retry after drain
        idle("bp.drain", 1);
        for (int k = 0; k < 4; k++)
            step("bp.a", 1, 'h1100, VA'('h3000 + 16 * k), 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle("bp.hold", 0);
            chk("bp.hold_ea", 64'(ea_o), 64'h3030);
        end
        for (int k = 0; k < 4; k++)
            step("bp.b", 1, 'h1200, VA'('h7000 + 8 * k), 0, 0);
        chk("bp.dropped_pc", 64'(pc_o), 64'h1100);
        idle("bp.release", 1);
        step("bp.retry", 1, 'h1200, 'h7020, 0, 1);
        chk("bp.retry_pc", 64'(pc_o), 64'h1200);
        chk("bp.retry_ea", 64'(ea_o), 64'h7020);
        idle("bp.done", 1);

        // untrainable deltas: zero, oversized, descending
        for (int k = 0; k < 5; k++) begin
            step("zero", 1, 'h1300, 'h4000, 0, 1);
            step("big",  1, 'h1304, VA'('h5000 + 'h100 * k), 0, 1);
            step("neg",  1, 'h1308, VA'('h6000 - 8 * k), 0, 1);
            chk("untrain.v", 64'(v_o), 64'd0);
        end

        // replacement: nine PCs, the ninth evicts the first
        step("repl.flush", 0, '0, '0, 1, 1);
        for (int p = 0; p < 9; p++)
            for (int k = 0; k < 3; k++)
                step("repl.train", 1, VA'('h100 * (p + 1)),
                     VA'('h10000 * (p + 1) + 8 * k), 0, 1);
        step("repl.re", 1, 'h100, 'h10018, 0, 1);
        chk("repl.realloc_v", 64'(v_o), 64'd0);
        step("repl.re", 1, 'h100, 'h10020, 0, 1);
        step("repl.re", 1, 'h100, 'h10028, 0, 1);
        chk("repl.no_early_v", 64'(v_o), 64'd0);
        step("repl.re", 1, 'h100, 'h10030, 0, 1);
        chk("repl.retrain_v", 64'(v_o), 64'd1);

        // flush beats a concurrent commit and a pending descriptor
        idle("fl.drain", 1);
        for (int k = 0; k < 4; k++)
            step("fl.train", 1, 'h1400, VA'('h8000 + 8 * k), 0, 0);
        chk("fl.pending_v", 64'(v_o), 64'd1);
        step("fl.flush", 1, 'h1400, 'h8020, 1, 0);
        chk("fl.v_cleared", 64'(v_o), 64'd0);
        for (int k = 4; k < 7; k++)
            step("fl.re", 1, 'h1400, VA'('h8000 + 8 * k), 0, 1);
        chk("fl.no_early_v", 64'(v_o), 64'd0);
        step("fl.re", 1, 'h1400, 'h8038, 0, 1);
        chk("fl.retrain_v", 64'(v_o), 64'd1);

        // asynchronous reset mid-stream
        for (int k = 0; k < 4; k++)
            step("ar.train", 1, 'h1500, VA'('h9000 + 8 * k), 0, 0);
        chk("ar.pending_v", 64'(v_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("ar.v", 64'(v_o), 64'd0);
        chk("ar.ea", 64'(ea_o), 64'd0);
        #1 rst_n = 1'b1;
        for (int k = 4; k < 7; k++)
            step("ar.re", 1, 'h1500, VA'('h9000 + 8 * k), 0, 1);
        chk("ar.no_early_v", 64'(v_o), 64'd0);
        step("ar.re", 1, 'h1500, 'h9038, 0, 1);
        chk("ar.retrain_v", 64'(v_o), 64'd1);
        chk("ar.retrain_ea", 64'(ea_o), 64'h9038);

        // randomized mix of streams, jumps, backpressure and flushes
        for (int i = 0; i < 10; i++) begin
            r_pc[i]  = VA'('h40000 + 4 * i);
            r_cur[i] = VA'($urandom_range(32'h0fff_ffff, 0));
            case ($urandom_range(5, 0))
                0:       r_str[i] = 0;
                1:       r_str[i] = 'h100 + $urandom_range(64, 0);
                2:       r_str[i] = -8;
                default: r_str[i] = 1 << $urandom_range(6, 0);
            endcase
        end
        for (int c = 0; c < 3000; c++) begin
            int  p;
            bit  cv, fl, rdy;
            p   = $urandom_range(9, 0);
            if (c % 200 < 100) p = p % 4;
            cv  = ($urandom_range(9, 0) < 7);
            fl  = ($urandom_range(199, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);
            if (cv) begin
                if ($urandom_range(19, 0) == 0)
                    r_cur[p] = r_cur[p] + VA'($urandom_range(40, 1));
                else
                    r_cur[p] = r_cur[p] + VA'(r_str[p]);
            end
            step("rand", cv, r_pc[p], r_cur[p], fl, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
